fetch_seq_ctrl: RTL and testbench
=================================

Name:
fetch_seq_ctrl

Overview:
- Multicycle instruction-fetch sequencer for the RV32 core. Owns the architectural PC register.
- Issues one instruction-memory request at a time and presents the fetched instruction to decode over a valid/ready handshake.
- Applies redirects from branch/jump resolution using the same rule as the next-PC logic: sequential PC+4, or taken target = base + offset.
- Sits between instruction memory and the decode stage.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
halt  input  1  when 1, no new fetch is started; an in-flight fetch still completes.
redirect_valid  input  1  single-cycle pulse; redirect to a new target.
redirect_base  input  32  PC of the resolving branch/jump.
redirect_offset  input  32  signed byte offset added to redirect_base.
imem_req_valid  output  1  instruction memory request valid.
imem_req_addr  output  32  request word address, always 4-byte aligned.
imem_req_ready  input  1  memory accepts the request this cycle.
imem_rsp_valid  input  1  response data valid; at most one response per accepted request.
imem_rsp_data  input  32  returned instruction word.
if_valid  output  1  instruction presented to decode.
if_pc  output  32  PC of the presented instruction.
if_instr  output  32  presented instruction word.
if_ready  input  1  decode accepts the presented instruction.
fetch_pc  output  32  current pc_q, for debug/trace.
misalign_err  output  1  one-cycle pulse: redirect target had bits [1:0] != 0.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc_q=RESET_PC, state=IDLE, discard=0.
  - if_valid=0, if_pc=0, if_instr=0, misalign_err=0, imem_req_valid=0.
  - All state is cleared immediately, including mid-transaction.
- States: IDLE, REQ, WAIT, HOLD. Outputs are registered except imem_req_valid=(state==REQ) and imem_req_addr=pc_q.
- IDLE:
  - If !halt, go to REQ next cycle.
  - The first request therefore appears in the 2nd cycle after rst_n rises.
- REQ:
  - When imem_req_ready=1: issued_pc<=pc_q, pc_q<=pc_q+4, go to WAIT.
  - Otherwise hold the request and its address stable.
- WAIT:
  - imem_rsp_valid=1 and discard=1: drop the data, discard<=0, go to REQ (or IDLE if halt).
  - imem_rsp_valid=1 and discard=0: if_pc<=issued_pc, if_instr<=imem_rsp_data, if_valid<=1, go to HOLD.
- HOLD:
  - if_valid, if_pc and if_instr stay stable while if_ready=0.
  - On if_ready=1: if_valid<=0, go to REQ (or IDLE if halt).
- PC arithmetic: 32-bit modulo 2^32, no overflow detection. 0xFFFF_FFFC+4 wraps to 0x0000_0000.
- Redirect target:
  - T = (redirect_base + redirect_offset) mod 2^32, with T[1:0] forced to 0.
  - misalign_err<=1 for one cycle if the raw sum has [1:0] != 0.
- Redirect, by state (redirect has priority over all other updates to pc_q):
  - Any state: pc_q<=T.
  - HOLD: if_valid<=0 (not consumed even if if_ready=1), go to REQ (or IDLE if halt).
  - REQ, handshake this cycle: the old-address request is in flight. Go to WAIT with discard<=1; pc_q<=T (not +4).
  - REQ, no handshake: stay in REQ; the next request uses T.
  - WAIT, no response this cycle: discard<=1.
  - WAIT, response this cycle: drop the response, go to REQ.
  - IDLE: only pc_q is updated.
- imem_rsp_valid outside WAIT is ignored.
- halt never cancels an accepted request; halt=1 in REQ before the handshake returns the FSM to IDLE.
- Throughput: at most one instruction per 3 cycles (REQ, WAIT, HOLD), plus memory latency.

Test Plan:
1. Reset, 1-cycle-latency memory, if_ready=1 -> if_pc sequence 0x0,0x4,0x8,0xC; each instruction word returned correctly; imem_req_addr aligned.
2. if_ready=0 for 5 cycles in HOLD -> if_valid, if_pc and if_instr stable; no new imem request issued; fetch resumes after acceptance.
3. Redirect in WAIT with base=0x100, offset=0xFFFF_FFF0 -> late response dropped; next request addr=0xF0; if_pc=0xF0.
4. Redirect in the same cycle as imem_rsp_valid, and in the same cycle as a REQ handshake -> neither old instruction reaches if_valid; next delivered if_pc = target.
5. RESET_PC=0xFFFF_FFF8 -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
6. Redirect base=0x200, offset=0x6 -> misalign_err pulses for 1 cycle; fetch addr=0x204.
7. halt asserted in WAIT -> the current instruction is delivered, then the FSM goes to IDLE with no request; deassert halt -> fetch resumes at the next pc.
8. rst_n low mid-WAIT -> outputs clear immediately; a stray response is ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_seq_ctrl_if.sv
// Instruction-memory request/response and decode-side valid/ready bundle
// between the fetch sequencer (master) and its neighbours (slave).
interface fetch_seq_ctrl_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;

    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
    );
endinterface

// File: rtl/fetch_seq_ctrl.sv
// Multicycle RV32 fetch sequencer: one outstanding imem request, PC ownership,
// redirect handling with discard of stale responses, decode valid/ready hand-off.
module fetch_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_base,
    input  logic [31:0]       redirect_offset,
    fetch_seq_ctrl_if.master  bus,
    output logic [31:0]       fetch_pc,
    output logic              misalign_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_pc, w_pc_next;
    logic [31:0] r_issued_pc, w_issued_pc_next;
    logic        r_discard, w_discard_next;
    logic        r_if_valid, w_if_valid_next;
    logic [31:0] r_if_pc, w_if_pc_next;
    logic [31:0] r_if_instr, w_if_instr_next;
    logic        r_misalign, w_misalign_next;

    logic [31:0] w_sum;
    logic [31:0] w_target;
    logic        w_handshake;
    state_t      w_resume;

    assign w_sum       = redirect_base + redirect_offset;
    assign w_target    = {w_sum[31:2], 2'b00};
    assign w_handshake = (r_state == REQ) && bus.imem_req_ready;
    assign w_resume    = halt ? IDLE : REQ;

    assign bus.imem_req_valid = (r_state == REQ);
    assign bus.imem_req_addr  = {r_pc[31:2], 2'b00};
    assign bus.if_valid       = r_if_valid;
    assign bus.if_pc          = r_if_pc;
    assign bus.if_instr       = r_if_instr;
    assign fetch_pc           = r_pc;
    assign misalign_err       = r_misalign;

    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_issued_pc_next = r_issued_pc;
        w_discard_next   = r_discard;
        w_if_valid_next  = r_if_valid;
        w_if_pc_next     = r_if_pc;
        w_if_instr_next  = r_if_instr;
        w_misalign_next  = 1'b0;

        if (redirect_valid) begin
            w_pc_next       = w_target;
            w_misalign_next = |w_sum[1:0];
        end

        case (r_state)
            IDLE: begin
                if (!halt) w_state_next = REQ;
            end
            REQ: begin
                if (w_handshake) begin
                    // The accepted request always carries the pre-redirect PC.
                    w_issued_pc_next = r_pc;
                    w_state_next     = WAIT;
                    if (redirect_valid) w_discard_next = 1'b1;
                    else                w_pc_next      = r_pc + 32'd4;
                end else if (halt) begin
                    w_state_next = IDLE;
                end
            end
            WAIT: begin
                if (bus.imem_rsp_valid) begin
                    w_discard_next = 1'b0;
                    if (r_discard || redirect_valid) begin
                        w_state_next = w_resume;
                    end else begin
                        w_if_valid_next = 1'b1;
                        w_if_pc_next    = r_issued_pc;
                        w_if_instr_next = bus.imem_rsp_data;
                        w_state_next    = HOLD;
                    end
                end else if (redirect_valid) begin
                    w_discard_next = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid || bus.if_ready) begin
                    w_if_valid_next = 1'b0;
                    w_state_next    = w_resume;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            r_issued_pc <= 32'd0;
            r_discard   <= 1'b0;
            r_if_valid  <= 1'b0;
            r_if_pc     <= 32'd0;
            r_if_instr  <= 32'd0;
            r_misalign  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_issued_pc <= w_issued_pc_next;
            r_discard   <= w_discard_next;
            r_if_valid  <= w_if_valid_next;
            r_if_pc     <= w_if_pc_next;
            r_if_instr  <= w_if_instr_next;
            r_misalign  <= w_misalign_next;
        end
    end

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed bench for fetch_seq_ctrl: sequential fetch, decode stall, redirects,
// misaligned target, halt, reset wrap and asynchronous mid-transaction reset.
module tb_fetch_seq_ctrl;

    localparam logic [31:0] RESET_PC2 = 32'hFFFF_FFF8;

    logic        clk;
    logic        rst_n;
    logic        halt;
    logic        redirect_valid;
    logic [31:0] redirect_base;
    logic [31:0] redirect_offset;
    logic [31:0] fetch_pc;
    logic        misalign_err;

    logic        halt2;
    logic        redirect_valid2;
    logic [31:0] redirect_base2;
    logic [31:0] redirect_offset2;
    logic [31:0] fetch_pc2;
    logic        misalign_err2;

    fetch_seq_ctrl_if ifc ();
    fetch_seq_ctrl_if ifc2 ();

    fetch_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .halt(halt),
        .redirect_valid(redirect_valid), .redirect_base(redirect_base),
        .redirect_offset(redirect_offset), .bus(ifc),
        .fetch_pc(fetch_pc), .misalign_err(misalign_err)
    );

    fetch_seq_ctrl #(.RESET_PC(RESET_PC2)) dut2 (
        .clk(clk), .rst_n(rst_n), .halt(halt2),
        .redirect_valid(redirect_valid2), .redirect_base(redirect_base2),
        .redirect_offset(redirect_offset2), .bus(ifc2),
        .fetch_pc(fetch_pc2), .misalign_err(misalign_err2)
    );

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          acc_count = 0;
    logic        mem_auto = 1'b1;
    logic [31:0] q2 [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // One clock; the automatic memory answers an accepted request one cycle later.
    task automatic step();
        logic        acc, acc2;
        logic [31:0] a, a2;
        acc  = mem_auto && ifc.imem_req_valid && ifc.imem_req_ready;
        a    = ifc.imem_req_addr;
        acc2 = ifc2.imem_req_valid && ifc2.imem_req_ready;
        a2   = ifc2.imem_req_addr;
        @(posedge clk);
        #1;
        cyc++;
        if (acc) acc_count++;
        if (mem_auto) begin
            ifc.imem_rsp_valid = acc;
            ifc.imem_rsp_data  = mem_word(a);
        end
        ifc2.imem_rsp_valid = acc2;
        ifc2.imem_rsp_data  = mem_word(a2);
        if (acc2) q2.push_back(a2);
    endtask

    task automatic wait_if(input string name);
        int n = 0;
        do begin
            step();
            n++;
        end while (!ifc.if_valid && n < 20);
        if (!ifc.if_valid) begin
            failures++;
            $display("FAIL %s timeout waiting for if_valid after %0d cycles", name, n);
            checks++;
        end else begin
            $display("txn %s pc=%h instr=%h cyc=%0d", name, ifc.if_pc, ifc.if_instr, cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
        redirect_base = 32'd0; redirect_offset = 32'd0;
        halt2 = 1'b0; redirect_valid2 = 1'b0; redirect_base2 = 32'd0; redirect_offset2 = 32'd0;
        ifc.imem_req_ready = 1'b1; ifc.imem_rsp_valid = 1'b0; ifc.imem_rsp_data = 32'd0;
        ifc.if_ready = 1'b1;
        ifc2.imem_req_ready = 1'b1; ifc2.imem_rsp_valid = 1'b0; ifc2.imem_rsp_data = 32'd0;
        ifc2.if_ready = 1'b1;
        repeat (3) step();
        checks++;
        if ({ifc.if_valid, ifc.if_pc, ifc.if_instr, misalign_err, ifc.imem_req_valid} !== 67'd0) begin
            failures++;
            $display("FAIL reset_outputs actual=%b/%h/%h/%b/%b required=all zero",
                     ifc.if_valid, ifc.if_pc, ifc.if_instr, misalign_err, ifc.imem_req_valid);
        end
        checks++;
        if (fetch_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_pc actual=%h required=%h", fetch_pc, 32'h0);
        end
        checks++;
        if (fetch_pc2 !== RESET_PC2) begin
            failures++;
            $display("FAIL reset_pc2 actual=%h required=%h", fetch_pc2, RESET_PC2);
        end
        rst_n = 1'b1;
        q2.delete();
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        checks++;
        if (ifc.imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_req actual=%b required=0", ifc.imem_req_valid);
        end
        step();
        checks++;
        if ({ifc.imem_req_valid, ifc.imem_req_addr} !== {1'b1, 32'h0}) begin
            failures++;
            $display("FAIL first_req actual=%b/%h required=1/00000000", ifc.imem_req_valid, ifc.imem_req_addr);
        end
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'(i * 4);
            wait_if("seq");
            checks++;
            if ({ifc.if_pc, ifc.if_instr} !== {exp_pc, mem_word(exp_pc)}) begin
                failures++;
                $display("FAIL seq_%0d actual=%h/%h required=%h/%h", i, ifc.if_pc, ifc.if_instr,
                         exp_pc, mem_word(exp_pc));
            end
        end
    endtask

    task automatic test_reset_pc_wrap();
        checks++;
        if (q2.size() < 3) begin
            failures++;
            $display("FAIL wrap_count actual=%0d required>=3", q2.size());
        end else if (q2[0] !== 32'hFFFF_FFF8 || q2[1] !== 32'hFFFF_FFFC || q2[2] !== 32'h0) begin
            failures++;
            $display("FAIL wrap_addrs actual=%h,%h,%h required=fffffff8,fffffffc,00000000",
                     q2[0], q2[1], q2[2]);
        end
    endtask

    task automatic test_hold();
        int acc_snap;
        step();
        ifc.if_ready = 1'b0;
        wait_if("hold");
        checks++;
        if (ifc.if_pc !== 32'h10) begin
            failures++;
            $display("FAIL hold_first actual=%h required=00000010", ifc.if_pc);
        end
        acc_snap = acc_count;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({ifc.if_valid, ifc.if_pc, ifc.if_instr, ifc.imem_req_valid} !==
                {1'b1, 32'h10, mem_word(32'h10), 1'b0}) begin
                failures++;
                $display("FAIL hold_stable_%0d actual=%b/%h/%h/%b required=1/00000010/%h/0", i,
                         ifc.if_valid, ifc.if_pc, ifc.if_instr, ifc.imem_req_valid, mem_word(32'h10));
            end
        end
        checks++;
        if (acc_count !== acc_snap) begin
            failures++;
            $display("FAIL hold_no_req actual=%0d required=%0d", acc_count, acc_snap);
        end
        ifc.if_ready = 1'b1;
        wait_if("hold_resume");
        checks++;
        if (ifc.if_pc !== 32'h14) begin
            failures++;
            $display("FAIL hold_resume actual=%h required=00000014", ifc.if_pc);
        end
    endtask

    task automatic test_redirect_wait();
        mem_auto = 1'b0; ifc.imem_req_ready = 1'b0;
        step();
        ifc.imem_req_ready = 1'b1;
        step();
        ifc.imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_base = 32'h100; redirect_offset = 32'hFFFF_FFF0;
        step();
        redirect_valid = 1'b0;
        checks++;
        if ({fetch_pc, misalign_err} !== {32'hF0, 1'b0}) begin
            failures++;
            $display("FAIL rdw_pc actual=%h/%b required=000000f0/0", fetch_pc, misalign_err);
        end
        ifc.imem_rsp_valid = 1'b1; ifc.imem_rsp_data = 32'hDEAD_BEEF;
        step();
        ifc.imem_rsp_valid = 1'b0;
        checks++;
        if ({ifc.if_valid, ifc.imem_req_valid, ifc.imem_req_addr} !== {1'b0, 1'b1, 32'hF0}) begin
            failures++;
            $display("FAIL rdw_drop actual=%b/%b/%h required=0/1/000000f0",
                     ifc.if_valid, ifc.imem_req_valid, ifc.imem_req_addr);
        end
        mem_auto = 1'b1; ifc.imem_req_ready = 1'b1;
        wait_if("rdw");
        checks++;
        if ({ifc.if_pc, ifc.if_instr} !== {32'hF0, mem_word(32'hF0)}) begin
            failures++;
            $display("FAIL rdw_deliver actual=%h/%h required=000000f0/%h", ifc.if_pc, ifc.if_instr,
                     mem_word(32'hF0));
        end
    endtask

    task automatic test_redirect_collide();
        mem_auto = 1'b0; ifc.imem_req_ready = 1'b0;
        step();
        ifc.imem_req_ready = 1'b1;
        step();
        ifc.imem_req_ready = 1'b0;
        ifc.imem_rsp_valid = 1'b1; ifc.imem_rsp_data = 32'hBAD0_0001;
        redirect_valid = 1'b1; redirect_base = 32'h300; redirect_offset = 32'h40;
        step();
        ifc.imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
        checks++;
        if ({ifc.if_valid, fetch_pc, ifc.imem_req_valid, ifc.imem_req_addr} !==
            {1'b0, 32'h340, 1'b1, 32'h340}) begin
            failures++;
            $display("FAIL rsp_collide actual=%b/%h/%b/%h required=0/00000340/1/00000340",
                     ifc.if_valid, fetch_pc, ifc.imem_req_valid, ifc.imem_req_addr);
        end
        ifc.imem_req_ready = 1'b1;
        redirect_valid = 1'b1; redirect_base = 32'h400; redirect_offset = 32'h10;
        step();
        redirect_valid = 1'b0; ifc.imem_req_ready = 1'b0;
        checks++;
        if ({fetch_pc, ifc.imem_req_valid} !== {32'h410, 1'b0}) begin
            failures++;
            $display("FAIL req_collide_pc actual=%h/%b required=00000410/0", fetch_pc, ifc.imem_req_valid);
        end
        ifc.imem_rsp_valid = 1'b1; ifc.imem_rsp_data = 32'hBAD0_0002;
        step();
        ifc.imem_rsp_valid = 1'b0;
        checks++;
        if ({ifc.if_valid, ifc.imem_req_valid, ifc.imem_req_addr} !== {1'b0, 1'b1, 32'h410}) begin
            failures++;
            $display("FAIL req_collide_drop actual=%b/%b/%h required=0/1/00000410",
                     ifc.if_valid, ifc.imem_req_valid, ifc.imem_req_addr);
        end
        mem_auto = 1'b1; ifc.imem_req_ready = 1'b1;
        wait_if("collide");
        checks++;
        if ({ifc.if_pc, ifc.if_instr} !== {32'h410, mem_word(32'h410)}) begin
            failures++;
            $display("FAIL collide_deliver actual=%h/%h required=00000410/%h", ifc.if_pc, ifc.if_instr,
                     mem_word(32'h410));
        end
    endtask

    task automatic test_misalign();
        mem_auto = 1'b0; ifc.imem_req_ready = 1'b0;
        step();
        redirect_valid = 1'b1; redirect_base = 32'h200; redirect_offset = 32'h6;
        step();
        redirect_valid = 1'b0;
        checks++;
        if ({misalign_err, ifc.imem_req_valid, ifc.imem_req_addr} !== {1'b1, 1'b1, 32'h204}) begin
            failures++;
            $display("FAIL misalign_set actual=%b/%b/%h required=1/1/00000204",
                     misalign_err, ifc.imem_req_valid, ifc.imem_req_addr);
        end
        step();
        checks++;
        if (misalign_err !== 1'b0) begin
            failures++;
            $display("FAIL misalign_pulse actual=%b required=0", misalign_err);
        end
        mem_auto = 1'b1; ifc.imem_req_ready = 1'b1;
        wait_if("misalign");
        checks++;
        if (ifc.if_pc !== 32'h204) begin
            failures++;
            $display("FAIL misalign_deliver actual=%h required=00000204", ifc.if_pc);
        end
    endtask

    task automatic test_halt();
        mem_auto = 1'b0; ifc.imem_req_ready = 1'b0;
        step();
        ifc.imem_req_ready = 1'b1;
        step();
        ifc.imem_req_ready = 1'b0;
        halt = 1'b1;
        ifc.imem_rsp_valid = 1'b1; ifc.imem_rsp_data = 32'h0051_8513;
        step();
        ifc.imem_rsp_valid = 1'b0;
        checks++;
        if ({ifc.if_valid, ifc.if_pc, ifc.if_instr} !== {1'b1, 32'h208, 32'h0051_8513}) begin
            failures++;
            $display("FAIL halt_deliver actual=%b/%h/%h required=1/00000208/00518513",
                     ifc.if_valid, ifc.if_pc, ifc.if_instr);
        end
        ifc.imem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({ifc.if_valid, ifc.imem_req_valid} !== 2'b00) begin
                failures++;
                $display("FAIL halt_idle_%0d actual=%b/%b required=0/0", i, ifc.if_valid, ifc.imem_req_valid);
            end
        end
        halt = 1'b0;
        step();
        checks++;
        if ({ifc.imem_req_valid, ifc.imem_req_addr} !== {1'b1, 32'h20C}) begin
            failures++;
            $display("FAIL halt_resume actual=%b/%h required=1/0000020c", ifc.imem_req_valid, ifc.imem_req_addr);
        end
        mem_auto = 1'b1;
        wait_if("halt");
        checks++;
        if (ifc.if_pc !== 32'h20C) begin
            failures++;
            $display("FAIL halt_next actual=%h required=0000020c", ifc.if_pc);
        end
    endtask

    task automatic test_reset_mid_wait();
        mem_auto = 1'b0; ifc.imem_req_ready = 1'b0;
        step();
        ifc.imem_req_ready = 1'b1;
        step();
        ifc.imem_req_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fetch_pc, ifc.if_pc, ifc.if_valid, ifc.imem_req_valid} !== 66'd0) begin
            failures++;
            $display("FAIL async_reset actual=%h/%h/%b/%b required=0/0/0/0",
                     fetch_pc, ifc.if_pc, ifc.if_valid, ifc.imem_req_valid);
        end
        step();
        rst_n = 1'b1;
        ifc.imem_rsp_valid = 1'b1; ifc.imem_rsp_data = 32'hBAD0_0003;
        step();
        ifc.imem_rsp_valid = 1'b0;
        checks++;
        if ({ifc.if_valid, ifc.imem_req_valid, ifc.imem_req_addr} !== {1'b0, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL stray_rsp actual=%b/%b/%h required=0/1/00000000",
                     ifc.if_valid, ifc.imem_req_valid, ifc.imem_req_addr);
        end
        mem_auto = 1'b1; ifc.imem_req_ready = 1'b1;
        wait_if("restart");
        checks++;
        if ({ifc.if_pc, ifc.if_instr} !== {32'h0, mem_word(32'h0)}) begin
            failures++;
            $display("FAIL restart actual=%h/%h required=00000000/%h", ifc.if_pc, ifc.if_instr,
                     mem_word(32'h0));
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_reset_pc_wrap();
        test_hold();
        test_redirect_wait();
        test_redirect_collide();
        test_misalign();
        test_halt();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
